// File: rtl/gray_pkg.sv
// Shared definitions for the Gray/binary conversion pipeline.
// Holds the mode encoding and the word-level conversion/adjacency helpers.
// Helpers operate on MAX_WIDTH-bit words; only the low 'width' bits are used.
package gray_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    // Gray to binary: a running XOR from the MSB down.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g,
                                                      input int unsigned         width);
        logic [MAX_WIDTH-1:0] b;
        logic                 acc;
        int                   idx;
        b   = '0;
        acc = 1'b0;
        for (int i = 0; i < int'(MAX_WIDTH); i++) begin
            idx = int'(MAX_WIDTH) - 1 - i;
            if (idx < int'(width)) begin
                acc    = acc ^ g[idx];
                b[idx] = acc;
            end
        end
        return b;
    endfunction

    // Binary to Gray: each bit XORed with its upper neighbour; the MSB passes through.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b,
                                                      input int unsigned         width);
        logic [MAX_WIDTH-1:0] g;
        logic [MAX_WIDTH-1:0] sh;
        g  = '0;
        sh = b >> 1;
        for (int i = 0; i < int'(MAX_WIDTH); i++) begin
            if (i < int'(width)) begin
                g[i] = b[i] ^ ((i == int'(width) - 1) ? 1'b0 : sh[i]);
            end
        end
        return g;
    endfunction

    // True when exactly one bit of x is set.
    function automatic logic popcount_is_one(input logic [MAX_WIDTH-1:0] x);
        return (x != '0) && ((x & (x - MAX_WIDTH'(1))) == '0);
    endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// Single valid/ready register slice carrying {mode, data, err}.
// Ports: clk, rst_n (async active-low), flush_i (sync clear of valid),
//        valid_i/mode_i/data_i/err_i (upstream beat), ready_i (downstream advances),
//        valid_o/mode_o/data_o/err_o (registered beat held in this slice).
// The slice loads whenever it is empty or its downstream advances, so a
// chain of slices has no bubbles.
module gray_pipe_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             err_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic             mode_o,
    output logic [WIDTH-1:0] data_o,
    output logic             err_o
);

    logic             valid_q, valid_d;
    logic             mode_q,  mode_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             err_q,   err_d;
    logic             adv_c;

    assign adv_c = !valid_q || ready_i;

    // Next-state: flush empties the slice, otherwise load on advance.
    always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        data_d  = data_q;
        err_d   = err_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (adv_c) begin
            valid_d = valid_i;
            if (valid_i) begin
                mode_d = mode_i;
                data_d = data_i;
                err_d  = err_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign valid_o = valid_q;
    assign mode_o  = mode_q;
    assign data_o  = data_q;
    assign err_o   = err_q;

endmodule

// File: rtl/gray_bin_conv_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready on both sides.
// Parameters: WIDTH (2..32) word width, STAGES (1..4) register stages.
// Ports: clk, rst_n (async active-low), flush (sync drop of in-flight beats),
//        in_valid/in_ready/in_mode/in_data (input stream, mode 0 = Gray-to-binary,
//        1 = binary-to-Gray), out_valid/out_ready/out_mode/out_data (output stream),
//        adj_err (only with GRAY_ADJ_CHECK_EN: Gray input was not a single-bit step).
// in_ready is combinational from out_ready through the stage chain.
module gray_bin_conv_pipe
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
`ifdef GRAY_ADJ_CHECK_EN
    output logic             adj_err,
`endif
    output logic [WIDTH-1:0] out_data
);

    logic [STAGES:0]               rdy_c;
    logic                          in_fire;
    logic [WIDTH-1:0]              conv_data;
    logic                          conv_err;

    logic [STAGES-1:0]             sin_vld;
    logic [STAGES-1:0]             sin_mode;
    logic [STAGES-1:0][WIDTH-1:0]  sin_data;
    logic [STAGES-1:0]             sin_err;
    logic [STAGES-1:0]             st_vld;
    logic [STAGES-1:0]             st_mode;
    logic [STAGES-1:0][WIDTH-1:0]  st_data;
    logic [STAGES-1:0]             st_err;

    // Advance chain: a stage moves when empty or when the one after it moves.
    always_comb begin
        rdy_c         = '0;
        rdy_c[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            rdy_c[k] = !st_vld[k] || rdy_c[k+1];
        end
    end

    assign in_ready = rdy_c[0] && !flush;
    assign in_fire  = in_valid && in_ready;

    // Conversion of the accepted word, registered into stage 0.
    always_comb begin
        conv_data = '0;
        if (in_mode == MODE_G2B) begin
            conv_data = WIDTH'(gray2bin(MAX_WIDTH'(in_data), WIDTH));
        end else begin
            conv_data = WIDTH'(bin2gray(MAX_WIDTH'(in_data), WIDTH));
        end
    end

`ifdef GRAY_ADJ_CHECK_EN
    logic [WIDTH-1:0] hist_q, hist_d;
    logic             hist_vld_q, hist_vld_d;

    // Adjacency history tracks only accepted Gray-to-binary inputs.
    always_comb begin
        hist_d     = hist_q;
        hist_vld_d = hist_vld_q;
        conv_err   = 1'b0;
        if (flush) begin
            hist_d     = '0;
            hist_vld_d = 1'b0;
        end else if (in_fire && (in_mode == MODE_G2B)) begin
            conv_err   = hist_vld_q && !popcount_is_one(MAX_WIDTH'(in_data ^ hist_q));
            hist_d     = in_data;
            hist_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
        end else begin
            hist_q     <= hist_d;
            hist_vld_q <= hist_vld_d;
        end
    end

    assign adj_err = st_err[STAGES-1];
`else
    logic unused_err;

    assign conv_err   = 1'b0;
    assign unused_err = st_err[STAGES-1];
`endif

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        if (k == 0) begin : g_src
            assign sin_vld[k]  = in_fire;
            assign sin_mode[k] = in_mode;
            assign sin_data[k] = conv_data;
            assign sin_err[k]  = conv_err;
        end else begin : g_src
            assign sin_vld[k]  = st_vld[k-1];
            assign sin_mode[k] = st_mode[k-1];
            assign sin_data[k] = st_data[k-1];
            assign sin_err[k]  = st_err[k-1];
        end

        gray_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (flush),
            .valid_i (sin_vld[k]),
            .mode_i  (sin_mode[k]),
            .data_i  (sin_data[k]),
            .err_i   (sin_err[k]),
            .ready_i (rdy_c[k+1]),
            .valid_o (st_vld[k]),
            .mode_o  (st_mode[k]),
            .data_o  (st_data[k]),
            .err_o   (st_err[k])
        );
    end

    assign out_valid = st_vld[STAGES-1];
    assign out_mode  = st_mode[STAGES-1];
    assign out_data  = st_data[STAGES-1];

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Directed bench for gray_bin_conv_pipe: a 4-bit/2-stage instance and a
// 32-bit/4-stage instance. Adjacency checks compile in with GRAY_ADJ_CHECK_EN.
module tb_gray_bin_conv_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic [3:0]  in_data, out_data;
    logic        adj_err;

    logic        w_flush, w_in_valid, w_in_ready, w_in_mode, w_out_valid, w_out_ready, w_out_mode;
    logic [31:0] w_in_data, w_out_data;
    logic        w_adj_err;

    gray_bin_conv_pipe #(.WIDTH(4), .STAGES(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
`ifdef GRAY_ADJ_CHECK_EN
        .adj_err   (adj_err),
`endif
        .out_data  (out_data)
    );

    gray_bin_conv_pipe #(.WIDTH(32), .STAGES(4)) u_dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (w_flush),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_mode   (w_in_mode),
        .in_data   (w_in_data),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_mode  (w_out_mode),
`ifdef GRAY_ADJ_CHECK_EN
        .adj_err   (w_adj_err),
`endif
        .out_data  (w_out_data)
    );

`ifndef GRAY_ADJ_CHECK_EN
    assign adj_err   = 1'b0;
    assign w_adj_err = 1'b0;
`endif

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [3:0] gray_tab [16];
    logic [3:0] s_d [16];
    logic       s_m [16];
    logic [3:0] e_d [16];
    logic       e_m [16];
    logic       e_e [16];
    logic [3:0] got [16];
    logic [3:0] bp_in [6];
    logic [3:0] bp_exp [6];
    logic [3:0] mx_in [5];
    logic       mx_m [5];
    logic [3:0] mx_exp [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Streams n beats with out_ready held high; results expected two cycles later.
    task automatic run_beats(input int n);
        for (int c = 0; c < n + 2; c++) begin
            out_ready = 1'b1;
            if (c < n) begin
                in_valid = 1'b1;
                in_mode  = s_m[c];
                in_data  = s_d[c];
            end else begin
                in_valid = 1'b0;
                in_data  = 4'h0;
            end
            @(negedge clk);
            if (c < n) chk("rs_in_ready", 32'(in_ready), 32'(1));
            chk("rs_out_valid", 32'(out_valid), 32'(c >= 2));
            if (c >= 2) begin
                chk("rs_data", 32'(out_data), 32'(e_d[c-2]));
                chk("rs_mode", 32'(out_mode), 32'(e_m[c-2]));
`ifdef GRAY_ADJ_CHECK_EN
                chk("rs_adj", 32'(adj_err), 32'(e_e[c-2]));
`endif
                got[c-2] = out_data;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic flush_cycle();
        flush    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("fc_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        bp_in    = '{4'h3, 4'h6, 4'h5, 4'hC, 4'hF, 4'h9};
        bp_exp   = '{4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hE};
        mx_in    = '{4'h3, 4'h5, 4'h6, 4'h8, 4'h8};
        mx_m     = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        mx_exp   = '{4'h2, 4'h7, 4'h4, 4'hC, 4'hF};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = 4'h0; out_ready = 1'b1;
        w_flush = 1'b0; w_in_valid = 1'b0; w_in_mode = 1'b0; w_in_data = 32'h0; w_out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_mode", 32'(out_mode), 32'(0));
        chk("rst_adj", 32'(adj_err), 32'(0));
        chk("rst_w_out_valid", 32'(w_out_valid), 32'(0));
        chk("rst_w_out_data", w_out_data, 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_w_in_ready", 32'(w_in_ready), 32'(1));
        @(posedge clk); #1;

        // Exhaustive Gray-to-binary
        for (int i = 0; i < 16; i++) begin
            s_d[i] = gray_tab[i]; s_m[i] = 1'b0;
            e_d[i] = 4'(i);       e_m[i] = 1'b0; e_e[i] = 1'b0;
        end
        run_beats(16);

        // Binary-to-Gray, then feed the results back as Gray
        for (int i = 0; i < 16; i++) begin
            s_d[i] = 4'(i);       s_m[i] = 1'b1;
            e_d[i] = gray_tab[i]; e_m[i] = 1'b1; e_e[i] = 1'b0;
        end
        run_beats(16);
        for (int i = 0; i < 16; i++) begin
            s_d[i] = got[i]; s_m[i] = 1'b0;
            e_d[i] = 4'(i);  e_m[i] = 1'b0; e_e[i] = 1'b0;
        end
        run_beats(16);

        // Back-pressure: out_ready low for cycles 2..6
        begin
            int idx, oidx, occ;
            logic hs_in, hs_out;
            idx = 0; oidx = 0; occ = 0;
            for (int c = 0; c < 30 && oidx < 6; c++) begin
                out_ready = !(c >= 2 && c < 7);
                in_valid  = (idx < 6);
                in_mode   = 1'b0;
                in_data   = (idx < 6) ? bp_in[idx] : 4'h0;
                @(negedge clk);
                chk("bp_in_ready", 32'(in_ready), 32'(out_ready || (occ < 2)));
                if (c == 3) chk("bp_ready_drop", 32'(in_ready), 32'(0));
                if (out_valid) chk("bp_data", 32'(out_data), 32'(bp_exp[oidx]));
                hs_out = out_valid && out_ready;
                hs_in  = in_valid && in_ready;
                if (hs_out) oidx++;
                if (hs_in)  idx++;
                occ = occ + int'(hs_in) - int'(hs_out);
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            chk("bp_count", 32'(oidx), 32'(6));
        end
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'(0));
        @(posedge clk); #1;

        // Mixed modes, then flush with two beats in flight
        for (int c = 0; c < 5; c++) begin
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_mode   = mx_m[c];
            in_data   = mx_in[c];
            @(negedge clk);
            if (c >= 2) begin
                chk("mx_valid", 32'(out_valid), 32'(1));
                chk("mx_data", 32'(out_data), 32'(mx_exp[c-2]));
                chk("mx_mode", 32'(out_mode), 32'(mx_m[c-2]));
            end
            @(posedge clk); #1;
        end
        flush = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_data = 4'hF;
        @(negedge clk);
        chk("fl_in_ready", 32'(in_ready), 32'(0));
        chk("fl_held_data", 32'(out_data), 32'(mx_exp[3]));
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("fl_in_ready_after", 32'(in_ready), 32'(1));
        chk("fl_cleared_0", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_cleared_1", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("fl_next_valid", 32'(out_valid), 32'(1));
        chk("fl_next_data", 32'(out_data), 32'(4'hA));
        chk("fl_next_mode", 32'(out_mode), 32'(0));
        chk("fl_next_adj", 32'(adj_err), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("fl_empty", 32'(out_valid), 32'(0));
        @(posedge clk); #1;

        // Wide/deep instance: latency of 4 and bit-pattern corners
        for (int c = 0; c < 7; c++) begin
            w_in_valid = (c < 2);
            w_in_mode  = 1'b0;
            w_in_data  = (c == 0) ? 32'hFFFF_FFFF : ((c == 1) ? 32'h8000_0000 : 32'h0);
            @(negedge clk);
            chk("w_out_valid", 32'(w_out_valid), 32'(c == 4 || c == 5));
            if (c == 4) begin
                chk("w_data_ffff", w_out_data, 32'hAAAA_AAAA);
                chk("w_adj_first", 32'(w_adj_err), 32'(0));
            end
            if (c == 5) begin
                chk("w_data_8000", w_out_data, 32'hFFFF_FFFF);
`ifdef GRAY_ADJ_CHECK_EN
                chk("w_adj_multi", 32'(w_adj_err), 32'(1));
`endif
            end
            @(posedge clk); #1;
        end

        // Adjacency sequence after a flush
        flush_cycle();
        s_d[0] = 4'h0; s_d[1] = 4'h1; s_d[2] = 4'h7; s_d[3] = 4'h6;
        e_d[0] = 4'h0; e_d[1] = 4'h1; e_d[2] = 4'h5; e_d[3] = 4'h4;
        e_e[0] = 1'b0; e_e[1] = 1'b0; e_e[2] = 1'b1; e_e[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_m[i] = 1'b0; e_m[i] = 1'b0;
        end
        run_beats(4);
        flush_cycle();
        s_d[0] = 4'hF; e_d[0] = 4'hA; e_e[0] = 1'b0;
        run_beats(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
